// File: rtl/cp0_interrupt_unit.sv
// Purpose : CP0 Status/Cause/EPC registers, interrupt-take decision and ERET return.
// Latency : TakenInterrupt and rd_data are combinational; register updates land on the next rising edge.
// Backpressure: none; strobes (MTC0, ERET) and irq levels are sampled every cycle.
//
// Ports:
//   clock, reset            - system clock, asynchronous active-low reset
//   irq[7:0]                - level interrupt requests (irq[7] = TimerInterrupt)
//   regnum, wr_data, MTC0   - CP0 register select / write data / write strobe
//   ERET                    - return-from-exception strobe
//   next_pc[29:0]           - word address to resume at if an interrupt is taken
//   rd_data[31:0]           - MFC0 read data for regnum
//   EPC[29:0]               - saved return word address
//   TakenInterrupt          - redirect PC to the handler this cycle
module cp0_interrupt_unit #(
  parameter logic [31:0] STATUS_RESET = 32'h0000_0000,
  parameter logic [29:0] EPC_RESET    = 30'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  irq,
  input  logic [4:0]  regnum,
  input  logic [31:0] wr_data,
  input  logic        MTC0,
  input  logic        ERET,
  input  logic [29:0] next_pc,
  output logic [31:0] rd_data,
  output logic [29:0] EPC,
  output logic        TakenInterrupt
);

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  // The EXL bit is the whole state machine: USER runs normally, HANDLER blocks interrupts.
  localparam logic [0:0] ST_USER    = 1'b0;
  localparam logic [0:0] ST_HANDLER = 1'b1;

  logic [7:0]  im_q,    im_d;
  logic        ie_q,    ie_d;
  logic [0:0]  state_q, state_d;
  logic [29:0] epc_q,   epc_d;

  logic wr_status;
  logic wr_epc;
  logic take;

  assign wr_status = MTC0 && (regnum == REG_STATUS);
  assign wr_epc    = MTC0 && (regnum == REG_EPC);

  // Gated by reset so the redirect is held low for the whole reset window,
  // even if STATUS_RESET enables interrupts.
  assign take = reset && (|(irq & im_q)) && ie_q && (state_q == ST_USER);

  assign TakenInterrupt = take;
  assign EPC            = epc_q;

  always_comb begin
    im_d    = im_q;
    ie_d    = ie_q;
    state_d = state_q;
    epc_d   = epc_q;

    if (wr_status) begin
      im_d    = wr_data[15:8];
      ie_d    = wr_data[0];
      state_d = wr_data[1];
    end

    if (wr_epc) begin
      epc_d = wr_data[31:2];
    end

    // ERET in HANDLER beats a software write of EXL on the same edge.
    if (ERET && (state_q == ST_HANDLER)) begin
      state_d = ST_USER;
    end

    // A taken interrupt has the final say on EXL and EPC.
    if (take) begin
      state_d = ST_HANDLER;
      epc_d   = next_pc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      im_q    <= STATUS_RESET[15:8];
      ie_q    <= STATUS_RESET[0];
      state_q <= STATUS_RESET[1];
      epc_q   <= EPC_RESET;
    end else begin
      im_q    <= im_d;
      ie_q    <= ie_d;
      state_q <= state_d;
      epc_q   <= epc_d;
    end
  end

  // Cause reflects the live irq lines, so reads track irq within the cycle.
  always_comb begin
    rd_data = 32'h0;
    case (regnum)
      REG_STATUS: rd_data = {16'h0, im_q, 6'h0, state_q, ie_q};
      REG_CAUSE:  rd_data = {16'h0, irq, 8'h0};
      REG_EPC:    rd_data = {epc_q, 2'b00};
      default:    rd_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0_interrupt_unit.sv
// Directed bench for cp0_interrupt_unit: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_cp0_interrupt_unit;

  logic        clock;
  logic        reset;
  logic [7:0]  irq;
  logic [4:0]  regnum;
  logic [31:0] wr_data;
  logic        MTC0;
  logic        ERET;
  logic [29:0] next_pc;
  logic [31:0] rd_data;
  logic [29:0] EPC;
  logic        TakenInterrupt;

  int checks = 0;
  int errors = 0;

  cp0_interrupt_unit dut (
    .clock          (clock),
    .reset          (reset),
    .irq            (irq),
    .regnum         (regnum),
    .wr_data        (wr_data),
    .MTC0           (MTC0),
    .ERET           (ERET),
    .next_pc        (next_pc),
    .rd_data        (rd_data),
    .EPC            (EPC),
    .TakenInterrupt (TakenInterrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic write_status(input logic [31:0] v);
    regnum = 5'd12; wr_data = v; MTC0 = 1'b1;
    step();
    MTC0 = 1'b0; wr_data = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0; irq = 8'hFF; regnum = 5'd12; wr_data = 32'h0;
    MTC0 = 1'b0; ERET = 1'b0; next_pc = 30'h0;
    #12;
    checks++;
    if (TakenInterrupt !== 1'b0) begin
      errors++; $display("FAIL reset_taken: got %b want 0", TakenInterrupt);
    end
    checks++;
    if (EPC !== 30'h0) begin
      errors++; $display("FAIL reset_epc: got %h want 0", EPC);
    end
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (rd_data !== 32'h0) begin
      errors++; $display("FAIL reset_status: got %h want 00000000", rd_data);
    end
    regnum = 5'd13;
    #1;
    checks++;
    if (rd_data !== 32'h0000_FF00) begin
      errors++; $display("FAIL reset_cause: got %h want 0000ff00", rd_data);
    end
    irq = 8'h00;
    step();
  endtask

  task automatic test_register_map();
    // EPC write takes bits [31:2]
    regnum = 5'd14; wr_data = 32'hABCD_1237; MTC0 = 1'b1;
    step();
    MTC0 = 1'b0;
    checks++;
    if (EPC !== 30'h2AF3_448D) begin
      errors++; $display("FAIL map_epc_write: got %h want 2af3448d", EPC);
    end
    checks++;
    if (rd_data !== 32'hABCD_1234) begin
      errors++; $display("FAIL map_epc_read: got %h want abcd1234", rd_data);
    end
    // Cause is read-only and follows irq within the cycle
    irq = 8'h05; regnum = 5'd13; wr_data = 32'hFFFF_FFFF; MTC0 = 1'b1;
    step();
    MTC0 = 1'b0;
    checks++;
    if (rd_data !== 32'h0000_0500) begin
      errors++; $display("FAIL map_cause_ro: got %h want 00000500", rd_data);
    end
    irq = 8'h30;
    #1;
    checks++;
    if (rd_data !== 32'h0000_3000) begin
      errors++; $display("FAIL map_cause_live: got %h want 00003000", rd_data);
    end
    irq = 8'h00;
    regnum = 5'd12;
    #1;
    checks++;
    if (rd_data !== 32'h0) begin
      errors++; $display("FAIL map_cause_wr_status: got %h want 00000000", rd_data);
    end
    // Unimplemented registers ignore writes and read 0
    regnum = 5'd5; wr_data = 32'h1234_5678; MTC0 = 1'b1;
    step();
    MTC0 = 1'b0;
    checks++;
    if (rd_data !== 32'h0) begin
      errors++; $display("FAIL map_other_reg: got %h want 00000000", rd_data);
    end
    // Only IM, EXL and IE stick in Status
    write_status(32'hFFFF_FFFE);
    checks++;
    if (rd_data !== 32'h0000_FF02) begin
      errors++; $display("FAIL map_status_bits: got %h want 0000ff02", rd_data);
    end
    write_status(32'h0);
    checks++;
    if (EPC !== 30'h2AF3_448D) begin
      errors++; $display("FAIL map_epc_hold: got %h want 2af3448d", EPC);
    end
  endtask

  task automatic test_masking();
    write_status(32'h0000_4001);
    irq = 8'h80;
    #1;
    checks++;
    if (TakenInterrupt !== 1'b0) begin
      errors++; $display("FAIL mask_im: got %b want 0", TakenInterrupt);
    end
    step();
    checks++;
    if (rd_data !== 32'h0000_4001) begin
      errors++; $display("FAIL mask_im_status: got %h want 00004001", rd_data);
    end
    irq = 8'h00;
    write_status(32'h0000_8000);
    irq = 8'h80;
    #1;
    checks++;
    if (TakenInterrupt !== 1'b0) begin
      errors++; $display("FAIL mask_ie: got %b want 0", TakenInterrupt);
    end
    // ERET in USER leaves everything alone
    ERET = 1'b1;
    step();
    ERET = 1'b0;
    checks++;
    if (rd_data !== 32'h0000_8000) begin
      errors++; $display("FAIL eret_user_status: got %h want 00008000", rd_data);
    end
    checks++;
    if (EPC !== 30'h2AF3_448D) begin
      errors++; $display("FAIL eret_user_epc: got %h want 2af3448d", EPC);
    end
    irq = 8'h00;
  endtask

  task automatic test_timer_interrupt();
    write_status(32'h0000_8001);
    checks++;
    if (rd_data !== 32'h0000_8001) begin
      errors++; $display("FAIL timer_status_set: got %h want 00008001", rd_data);
    end
    irq = 8'h80; next_pc = 30'h0010_0004;
    #1;
    checks++;
    if (TakenInterrupt !== 1'b1) begin
      errors++; $display("FAIL timer_taken: got %b want 1", TakenInterrupt);
    end
    step();
    checks++;
    if (rd_data !== 32'h0000_8003) begin
      errors++; $display("FAIL timer_exl: got %h want 00008003", rd_data);
    end
    checks++;
    if (EPC !== 30'h0010_0004) begin
      errors++; $display("FAIL timer_epc: got %h want 00100004", EPC);
    end
    regnum = 5'd14;
    #1;
    checks++;
    if (rd_data !== 32'h0040_0010) begin
      errors++; $display("FAIL timer_epc_read: got %h want 00400010", rd_data);
    end
    checks++;
    if (TakenInterrupt !== 1'b0) begin
      errors++; $display("FAIL timer_blocked0: got %b want 0", TakenInterrupt);
    end
    next_pc = 30'h0000_0777;
    step();
    checks++;
    if (TakenInterrupt !== 1'b0 || EPC !== 30'h0010_0004) begin
      errors++; $display("FAIL timer_blocked1: got taken=%b epc=%h want 0/00100004", TakenInterrupt, EPC);
    end
  endtask

  task automatic test_eret_retake();
    // Still in HANDLER with irq[7] high from the previous task
    regnum = 5'd12; next_pc = 30'h0020_0000; ERET = 1'b1;
    step();
    ERET = 1'b0;
    checks++;
    if (rd_data !== 32'h0000_8001) begin
      errors++; $display("FAIL eret_exl_clear: got %h want 00008001", rd_data);
    end
    checks++;
    if (TakenInterrupt !== 1'b1 || EPC !== 30'h0010_0004) begin
      errors++; $display("FAIL eret_retake: got taken=%b epc=%h want 1/00100004", TakenInterrupt, EPC);
    end
    step();
    checks++;
    if (EPC !== 30'h0020_0000 || TakenInterrupt !== 1'b0) begin
      errors++; $display("FAIL eret_retake_epc: got epc=%h taken=%b want 00200000/0", EPC, TakenInterrupt);
    end
    // irq drops together with ERET: nothing retaken
    irq = 8'h00; ERET = 1'b1;
    step();
    ERET = 1'b0;
    checks++;
    if (TakenInterrupt !== 1'b0 || rd_data !== 32'h0000_8001) begin
      errors++; $display("FAIL eret_no_irq: got taken=%b status=%h want 0/00008001", TakenInterrupt, rd_data);
    end
  endtask

  task automatic test_collision();
    irq = 8'h80; next_pc = 30'h0000_1234;
    regnum = 5'd12; wr_data = 32'h0000_0001; MTC0 = 1'b1;
    #1;
    checks++;
    if (TakenInterrupt !== 1'b1) begin
      errors++; $display("FAIL coll_taken: got %b want 1", TakenInterrupt);
    end
    step();
    MTC0 = 1'b0;
    checks++;
    if (rd_data !== 32'h0000_0003) begin
      errors++; $display("FAIL coll_status: got %h want 00000003", rd_data);
    end
    checks++;
    if (EPC !== 30'h0000_1234) begin
      errors++; $display("FAIL coll_epc: got %h want 00001234", EPC);
    end
    // ERET + Status write in HANDLER: EXL cleared regardless of wr_data[1]
    wr_data = 32'h0000_8003; MTC0 = 1'b1; ERET = 1'b1;
    step();
    MTC0 = 1'b0; ERET = 1'b0;
    checks++;
    if (rd_data !== 32'h0000_8001 || TakenInterrupt !== 1'b1) begin
      errors++; $display("FAIL coll_eret_status: got %h taken=%b want 00008001/1", rd_data, TakenInterrupt);
    end
    // Taken interrupt + EPC write: next_pc wins
    next_pc = 30'h0000_5555; regnum = 5'd14; wr_data = 32'hFFFF_FFFC; MTC0 = 1'b1;
    step();
    MTC0 = 1'b0;
    checks++;
    if (EPC !== 30'h0000_5555) begin
      errors++; $display("FAIL coll_epc_write: got %h want 00005555", EPC);
    end
  endtask

  task automatic test_async_reset();
    // Currently in HANDLER with IE=1, IM=80
    regnum = 5'd12;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (rd_data !== 32'h0 || EPC !== 30'h0) begin
      errors++; $display("FAIL async_reset: got status=%h epc=%h want 00000000/0", rd_data, EPC);
    end
    checks++;
    if (TakenInterrupt !== 1'b0) begin
      errors++; $display("FAIL async_reset_taken: got %b want 0", TakenInterrupt);
    end
    step();
    reset = 1'b1;
    step();
    checks++;
    if (TakenInterrupt !== 1'b0) begin
      errors++; $display("FAIL async_post_reset: got %b want 0", TakenInterrupt);
    end
    // Pending irq is taken once software sets IE again
    write_status(32'h0000_8001);
    checks++;
    if (TakenInterrupt !== 1'b1) begin
      errors++; $display("FAIL async_reenable: got %b want 1", TakenInterrupt);
    end
    irq = 8'h00;
    step();
  endtask

  initial begin
    test_reset();
    test_register_map();
    test_masking();
    test_timer_interrupt();
    test_eret_retake();
    test_collision();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_interrupt_unit.md
Name: cp0_interrupt_unit

Overview:
- Coprocessor-0 interrupt unit that sits directly downstream of the memory-mapped timer and consumes its TimerInterrupt level on irq[7].
- Holds the Status, Cause and EPC registers, decides when an interrupt is taken, and captures the return PC.
- Drives the processor's PC-redirect to the handler and returns from the handler on ERET.
- MTC0/MFC0 access the registers through a 5-bit register number.

Parameters:
- STATUS_RESET, 32'h0000_0000: reset value of the Status register. Only bits [15:8], [1] and [0] are implemented; all other bits read 0.
- EPC_RESET, 30'h0: reset value of the EPC word address.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- irq  input  8  level interrupt requests; irq[7] is TimerInterrupt from the timer.
- regnum  input  5  CP0 register select for MTC0/MFC0.
- wr_data  input  32  MTC0 write data.
- MTC0  input  1  write strobe for the register selected by regnum.
- ERET  input  1  return-from-exception strobe.
- next_pc  input  30  word address of the instruction to resume at.
- rd_data  output  32  MFC0 read data (combinational).
- EPC  output  30  saved return word address.
- TakenInterrupt  output  1  redirect the PC to the handler this cycle.

Behaviour:
- Register map:
  - regnum 12, Status: [15:8] interrupt mask IM, [1] exception level EXL, [0] global enable IE.
  - regnum 13, Cause: [15:8] = irq (live, not latched); all other bits 0; read-only, so MTC0 to 13 is ignored.
  - regnum 14, EPC: reads as {EPC, 2'b00}. MTC0 loads wr_data[31:2].
  - Any other regnum reads 32'h0, and writes to it are ignored.
- Reset (reset=0, asynchronous):
  - Status = STATUS_RESET masked to the implemented bits.
  - EPC = EPC_RESET.
  - TakenInterrupt = 0 while reset is asserted.
  - rd_data follows the reset register contents.
- TakenInterrupt (combinational, zero latency): 1 when (|(irq & IM)) & IE & ~EXL; otherwise 0.
- On a rising edge with TakenInterrupt=1:
  - EXL := 1.
  - EPC := next_pc.
- EXL acts as a two-state machine:
  - USER (EXL=0) goes to HANDLER on a taken interrupt.
  - HANDLER (EXL=1) goes to USER on ERET.
  - Interrupts are blocked while in HANDLER.
- ERET:
  - In HANDLER, the next edge clears EXL; EPC is unchanged.
  - In USER, ERET has no effect on registers.
- Simultaneous events, same edge:
  - Taken interrupt + MTC0 Status: IM and IE take wr_data[15:8] and wr_data[0]; EXL is forced to 1 (interrupt wins bit 1).
  - Taken interrupt + MTC0 EPC: next_pc wins.
  - Taken interrupt + ERET (possible only in USER): the interrupt is taken normally.
  - ERET + MTC0 Status in HANDLER: IM and IE from wr_data; EXL := 0.
- Level semantics:
  - The unit never latches irq.
  - An interrupt still asserted after ERET (the timer was not acknowledged) is taken again on the first cycle after EXL clears.
  - irq dropping before the edge means nothing is taken.
- Reset mid-handler: EXL returns to its reset value immediately. Any pending irq is only taken once IE is set by software.
- rd_data is purely combinational from regnum and the current register and irq values, including irq changes within the cycle.

Test Plan:
- Reset value check:
  - Stimulus: reset=0 with irq=8'hFF.
  - Required: TakenInterrupt=0 and EPC=0. After release with regnum=12, rd_data=32'h0. With regnum=13, rd_data=32'h0000_FF00.
- Timer interrupt taken:
  - Stimulus: MTC0 Status=32'h0000_8001, then irq[7]=1 with next_pc=30'h0010_0004.
  - Required: TakenInterrupt=1 that cycle. After the edge, EXL=1, EPC=30'h0010_0004, rd_data(14)=32'h0040_0010, and TakenInterrupt=0 on following cycles.
- Masking:
  - Stimulus: Status=32'h0000_4001 with irq=8'h80; then Status=32'h0000_8000 (IE=0) with irq=8'h80.
  - Required: TakenInterrupt stays 0 in both cases.
- ERET re-take:
  - Stimulus: in HANDLER with irq[7] still 1, pulse ERET.
  - Required: EXL=0 after the edge. TakenInterrupt=1 on the next cycle, and EPC is updated to the then-current next_pc.
- Collision:
  - Stimulus: a taken interrupt on the same edge as MTC0 regnum 12 with wr_data=32'h0000_0001.
  - Required: Status reads 32'h0000_0003.
- Async reset in HANDLER:
  - Stimulus: assert reset between clock edges while in HANDLER.
  - Required: EXL=0 and EPC=0 immediately, without waiting for a clock edge.
